instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 7 +
 rtl/if_id_reg.sv | 36 +++
 rtl/instruction_fetch.sv | 75 +++++++
 tb/tb_instruction_fetch.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch constants, default parameters and fetch state encoding
package cpu_pkg;
    localparam logic [31:0] NOP               = 32'h0;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'd0;
    localparam int          DEFAULT_MEM_DEPTH = 100;
    typedef enum logic {RUN, HALT} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats load, load beats hold
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus1_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus1_o,
    output logic        valid_o
);
    logic [31:0] instr_q, instr_d, pc_plus1_q, pc_plus1_d;
    logic        valid_q, valid_d;
    always_comb begin
        instr_d    = flush ? NOP : load ? instr_i : instr_q;
        pc_plus1_d = flush ? 32'd0 : load ? pc_plus1_i : pc_plus1_q;
        valid_d    = !flush && (load || valid_q);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= NOP;
            pc_plus1_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
        end
    end
    assign instr_o    = instr_q;
    assign pc_plus1_o = pc_plus1_q;
    assign valid_o    = valid_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, fetch FSM and delivery counter; FETCH_BOUNDS_EN adds the out-of-range halt
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus1,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic        fault
);
`ifdef FETCH_BOUNDS_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif
    localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, count_q, count_d, pc_plus1;
    logic         fault_q, fault_d, halt, oob, ifid_load, ifid_flush;

    always_comb begin
        pc_plus1   = pc_q + 32'd1;
        halt       = state_q == HALT;
        oob        = BOUNDS_EN && !halt && !stall && pc_q >= DEPTH;
        ifid_load  = !halt && !stall && !oob;
        // HALT keeps IF/ID squashed so if_id_valid can never come back
        ifid_flush = flush || oob || halt;
        pc_d       = (halt || oob) ? pc_q : redirect_valid ? redirect_pc : stall ? pc_q : pc_plus1;
        state_d    = oob ? HALT : state_q;
        fault_d    = fault_q || oob;
        count_d    = (ifid_load && !flush && !(&count_q)) ? count_q + 32'd1 : count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (ifid_load),
        .flush      (ifid_flush),
        .instr_i    (imem_instr),
        .pc_plus1_i (pc_plus1),
        .instr_o    (if_id_instr),
        .pc_plus1_o (if_id_pc_plus1),
        .valid_o    (if_id_valid)
    );

    assign imem_addr   = pc_q;
    assign fetch_count = count_q;
    assign fault       = fault_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch against a behavioural fetch model
module tb_instruction_fetch;
    logic        clk = 1'b0, rst, stall, flush, redirect_valid;
    logic [31:0] redirect_pc, imem_addr, imem_instr, if_id_instr, if_id_pc_plus1, fetch_count;
    logic        if_id_valid, fault;
    int          n_tests = 0, n_fail = 0;

    typedef struct {
        logic [31:0] pc, instr, pp1, cnt;
        logic        valid, fault;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] m_pc, m_instr, m_pp1, m_cnt;
    logic        m_valid, m_fault, m_halt;

`ifdef FETCH_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        return a == 32'd0 ? 32'h80210010 : a == 32'd1 ? 32'h00431000 : (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction
    assign imem_instr = mem_at(imem_addr);

    instruction_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_id_instr(if_id_instr), .if_id_pc_plus1(if_id_pc_plus1),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count), .fault(fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_instr = 32'd0; m_pp1 = 32'd0; m_cnt = 32'd0;
        m_valid = 1'b0; m_fault = 1'b0; m_halt = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pc"}, imem_addr, m_pc);
        check({tag, ".instr"}, if_id_instr, m_instr);
        check({tag, ".pp1"}, if_id_pc_plus1, m_pp1);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        check({tag, ".cnt"}, fetch_count, m_cnt);
        check({tag, ".fault"}, {31'd0, fault}, {31'd0, m_fault});
    endtask

    task automatic cycle(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
        exp_t e, g;
        logic oob;
        stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
        #1 check("addr_pre", imem_addr, m_pc);
        oob = BOUNDS && !m_halt && !st && m_pc >= 32'd100;
        if (fl || oob || m_halt) begin
            m_instr = 32'd0; m_pp1 = 32'd0; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = mem_at(m_pc); m_pp1 = m_pc + 32'd1; m_valid = 1'b1;
            if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 32'd1;
        end
        if (!(m_halt || oob)) m_pc = rv ? rpc : st ? m_pc : m_pc + 32'd1;
        if (oob) begin m_halt = 1'b1; m_fault = 1'b1; end
        e.pc = m_pc; e.instr = m_instr; e.pp1 = m_pp1; e.cnt = m_cnt; e.valid = m_valid; e.fault = m_fault;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        check("sb.pc", imem_addr, g.pc);
        check("sb.instr", if_id_instr, g.instr);
        check("sb.pp1", if_id_pc_plus1, g.pp1);
        check("sb.valid", {31'd0, if_id_valid}, {31'd0, g.valid});
        check("sb.cnt", fetch_count, g.cnt);
        check("sb.fault", {31'd0, fault}, {31'd0, g.fault});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state("reset");
        rst = 1'b0;

        cycle(0, 0, 0, 0);
        check("e1.instr", if_id_instr, 32'h80210010);
        check("e1.pp1", if_id_pc_plus1, 32'd1);
        check("e1.valid", {31'd0, if_id_valid}, 32'd1);
        cycle(0, 0, 0, 0);
        check("e2.instr", if_id_instr, 32'h00431000);
        check("e2.cnt", fetch_count, 32'd2);
        repeat (2) cycle(0, 0, 0, 0);

        repeat (3) begin
            cycle(1, 0, 0, 0);
            check("stall.addr", imem_addr, 32'd4);
            check("stall.cnt", fetch_count, 32'd4);
            check("stall.pp1", if_id_pc_plus1, 32'd4);
        end

        cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 32'd2);
        check("rdfl.pc", imem_addr, 32'd2);
        check("rdfl.valid", {31'd0, if_id_valid}, 32'd0);
        cycle(0, 0, 0, 0);
        check("rdfl.pp1", if_id_pc_plus1, 32'd3);

        cycle(1, 0, 1, 32'd9);
        check("rdst.pc", imem_addr, 32'd9);
        check("rdst.pp1", if_id_pc_plus1, 32'd3);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 1, 32'd14);

        for (int i = 0; i < 40; i++)
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0, 32'($urandom_range(0, 30)));

        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd50;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        check_state("midrst");
        @(negedge clk) rst = 1'b0;
        cycle(0, 0, 0, 0);
        check("post_rst.instr", if_id_instr, 32'h80210010);

`ifdef FETCH_BOUNDS_EN
        cycle(0, 0, 1, 32'd99);
        cycle(0, 0, 0, 0);
        check("b.mem99", if_id_instr, mem_at(32'd99));
        check("b.pc100", imem_addr, 32'd100);
        cycle(0, 0, 0, 0);
        check("b.fault", {31'd0, fault}, 32'd1);
        check("b.valid", {31'd0, if_id_valid}, 32'd0);
        check("b.pc", imem_addr, 32'd100);
        cycle(0, 0, 1, 32'd3);
        cycle(1, 1, 1, 32'd4);
        check("b.halt_pc", imem_addr, 32'd100);
        @(negedge clk) rst = 1'b1;
        #1 model_reset();
        check("b.rst_fault", {31'd0, fault}, 32'd0);
        @(negedge clk) rst = 1'b0;
        cycle(0, 0, 0, 0);
`else
        cycle(0, 0, 1, 32'hFFFFFFFF);
        cycle(0, 0, 0, 0);
        check("wrap.pc", imem_addr, 32'd0);
        check("wrap.pp1", if_id_pc_plus1, 32'd0);
        check("wrap.fault", {31'd0, fault}, 32'd0);
        repeat (3) cycle(0, 0, 0, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
